// File: rtl/mux_arb_reg_if.sv
// Channel-side and output-side handshake bundle for mux_arb_reg.
interface mux_arb_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] d;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    s;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output d, in_valid, mode, s, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  d, in_valid, mode, s, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_arb_reg.sv
// N-channel mux with manual or round-robin selection feeding a single
// valid/ready output register stage with full throughput.
module mux_arb_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input logic          clk,
    input logic          reset,
    mux_arb_reg_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_ch_q;
    logic [SELW-1:0]  ptr_q;

    logic [WIDTH-1:0] ch_data [N];
    logic [SELW-1:0]  gnt;
    logic             gnt_valid;
    logic             load_en;
    logic             xfer;
    logic [N-1:0]     in_ready_c;

    // Unpack the flat channel bus into an indexable array.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = bus.d[i*WIDTH +: WIDTH];
    end

    // Grant selection: fixed channel in manual mode, rotating search from ptr+1 otherwise.
    always_comb begin
        logic [SELW-1:0] idx;
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        if (!bus.mode) begin
            gnt       = bus.s;
            gnt_valid = bus.in_valid[bus.s];
        end else begin
            for (int unsigned i = 1; i <= N; i++) begin
                idx = ptr_q + SELW'(i);
                if (!gnt_valid && bus.in_valid[idx]) begin
                    gnt_valid = 1'b1;
                    gnt       = idx;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state: the stage refills or drains whenever it may load, else holds.
    always_comb begin
        state_nxt = state_q;
        if (load_en) begin
            state_nxt = xfer ? FULL : EMPTY;
        end
    end

    // Outputs and handshake decode; reset masks every ready bit.
    always_comb begin
        bus.out_valid = (state_q == FULL);
        load_en       = (state_q == EMPTY) || bus.out_ready;
        in_ready_c    = '0;
        xfer          = 1'b0;
        if (!reset && gnt_valid && load_en) begin
            in_ready_c[gnt] = 1'b1;
            xfer            = 1'b1;
        end
        bus.in_ready = in_ready_c;
        bus.out_data = out_data_q;
        bus.out_ch   = out_ch_q;
    end

    // Output word, source channel and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q <= '0;
            out_ch_q   <= '0;
            ptr_q      <= SELW'(N - 1);
        end else if (xfer) begin
            out_data_q <= ch_data[gnt];
            out_ch_q   <= gnt;
            if (bus.mode) begin
                ptr_q <= gnt;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed self-checking bench for mux_arb_reg (WIDTH=8, N=4).
module tb_mux_arb_reg;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mux_arb_reg_if #(.WIDTH(WIDTH), .N(N)) bus ();

    mux_arb_reg #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tt [4];
        int         rr [6];
        tt = '{8'h11, 8'h22, 8'h33, 8'h44};
        rr = '{0, 1, 2, 3, 0, 1};
        checks = 0;
        errors = 0;

        // Reset with every channel requesting: nothing may be granted.
        reset         = 1'b1;
        bus.mode      = 1'b1;
        bus.s         = '0;
        bus.in_valid  = 4'b1111;
        bus.d         = 32'h44332211;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_data", 64'(bus.out_data), 64'h0);
        chk("rst_ch", 64'(bus.out_ch), 64'h0);

        // Manual select of channel 2.
        reset        = 1'b0;
        bus.mode     = 1'b0;
        bus.s        = 2'd2;
        bus.in_valid = 4'b0100;
        #1;
        chk("man_in_ready", 64'(bus.in_ready), 64'h4);
        tick();
        chk("man_data", 64'(bus.out_data), 64'h33);
        chk("man_ch", 64'(bus.out_ch), 64'h2);
        chk("man_valid", 64'(bus.out_valid), 64'h1);

        // Load 0x22 then apply backpressure for three cycles while d changes.
        bus.s        = 2'd1;
        bus.in_valid = 4'b0010;
        tick();
        chk("bp_load", 64'(bus.out_data), 64'h22);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            bus.d = 32'hA3A2A1A0 + 32'(k) * 32'h01010101;
            #1;
            chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
            tick();
            chk("bp_data_hold", 64'(bus.out_data), 64'h22);
            chk("bp_valid_hold", 64'(bus.out_valid), 64'h1);
        end
        bus.d         = 32'h5D5C5B5A;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'h2);
        tick();
        chk("bp_release_data", 64'(bus.out_data), 64'h5B);
        chk("bp_release_ch", 64'(bus.out_ch), 64'h1);

        // Manual blocked: selected channel idle, others valid.
        bus.in_valid = 4'b1101;
        #1;
        chk("blk_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        chk("blk_valid", 64'(bus.out_valid), 64'h0);
        chk("blk_data_hold", 64'(bus.out_data), 64'h5B);
        chk("blk_ch_hold", 64'(bus.out_ch), 64'h1);

        // 4:1 select truth table, back-to-back words.
        bus.d        = 32'h44332211;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.s = 2'(i);
            tick();
            chk("tt_data", 64'(bus.out_data), 64'(tt[i]));
            chk("tt_ch", 64'(bus.out_ch), 64'(i));
        end

        // Manual transfers must not have moved the pointer from 3.
        bus.mode = 1'b1;
        tick();
        chk("ptr_held_ch", 64'(bus.out_ch), 64'h0);

        // Round-robin rotation after a fresh reset.
        reset = 1'b1;
        tick();
        chk("rst2_valid", 64'(bus.out_valid), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_in_ready", 64'(bus.in_ready), 64'(4'b0001 << rr[i]));
            tick();
            chk("rr_ch", 64'(bus.out_ch), 64'(rr[i]));
            chk("rr_data", 64'(bus.out_data), 64'(tt[rr[i]]));
            chk("rr_valid", 64'(bus.out_valid), 64'h1);
        end

        // Sparse requests and wrap-around from channel 3.
        bus.in_valid = 4'b1000;
        tick();
        chk("sp_ch3", 64'(bus.out_ch), 64'h3);
        bus.in_valid = 4'b0100;
        #1;
        chk("sp_ready2", 64'(bus.in_ready), 64'h4);
        tick();
        chk("sp_ch2", 64'(bus.out_ch), 64'h2);
        bus.in_valid = 4'b0101;
        #1;
        chk("wrap_ready0", 64'(bus.in_ready), 64'h1);
        tick();
        chk("wrap_ch0", 64'(bus.out_ch), 64'h0);
        chk("wrap_data", 64'(bus.out_data), 64'h11);
        bus.in_valid = 4'b0000;
        tick();
        chk("rr_idle_valid", 64'(bus.out_valid), 64'h0);

        // Reset while holding 0x33 discards the word.
        bus.mode     = 1'b0;
        bus.s        = 2'd2;
        bus.in_valid = 4'b0100;
        tick();
        chk("mid_load", 64'(bus.out_data), 64'h33);
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.in_ready), 64'h0);
        tick();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
        chk("mid_rst_data", 64'(bus.out_data), 64'h0);
        chk("mid_rst_ch", 64'(bus.out_ch), 64'h0);
        reset         = 1'b0;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1010;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready), 64'h2);
        tick();
        chk("post_rst_ch", 64'(bus.out_ch), 64'h1);
        chk("post_rst_data", 64'(bus.out_data), 64'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
